quad_step_decoder: RTL and testbench
====================================

// Module: quad_step_decoder
// PURPOSE
//   Front-end for the 4-bit up/down counter stage. Converts two asynchronous quadrature
//   inputs (A/B) into a synchronous single-cycle step pulse plus a direction level.
//   The direction level feeds the counter's x input (1 = increment, 0 = decrement); step
//   is its advance enable. Provides 2-FF synchronisation, per-channel debounce, acquire
//   after reset, and illegal-transition detection.
// PARAMETERS
//   DEB_CYCLES  4  consecutive clk edges a synced channel must differ before the filtered value updates (>=2)
//   DEB_W       3  width of the per-channel debounce counter; must satisfy 2**DEB_W > DEB_CYCLES
// PORTS
//   clk      in   1  single system clock, rising edge
//   rst      in   1  synchronous, active-high reset
//   a_in     in   1  quadrature channel A, asynchronous
//   b_in     in   1  quadrature channel B, asynchronous
//   step     out  1  one-cycle pulse per legal quadrature transition
//   dir      out  1  direction of the last legal step: 1 = up (A leads B), 0 = down
//   err      out  1  one-cycle pulse when both filtered channels change on the same edge
//   state_q  out  2  current filtered {A,B}
// BEHAVIOUR
//   Reset (sync, rst high at an edge):
//     - Sync FFs, filtered values and debounce counters all 0; state_q = 2'b00.
//     - step = 0, err = 0, dir = 1; FSM enters ACQ.
//     - Reset mid-debounce or mid-acquire discards all progress; no pulse is ever emitted on the reset edge.
//   Synchroniser: a_in -> a_s1 -> a_s2 (same for b); only a_s2/b_s2 are used downstream.
//   FSM ACQ:
//     - Counts edges on which {a_s2,b_s2} equals its value on the previous edge; any change clears the count.
//     - After DEB_CYCLES consecutive stable edges: load filtered = {a_s2,b_s2}, go to TRACK.
//     - step/err stay 0; dir is unchanged.
//   FSM TRACK, per channel:
//     - If ch_s2 != ch_f: if cnt == DEB_CYCLES-1, set ch_f <= ch_s2 and cnt <= 0; otherwise cnt++.
//     - If ch_s2 == ch_f: cnt <= 0. A glitch shorter than DEB_CYCLES edges never reaches ch_f.
//   Transition decode, registered on the same edge the filtered value updates (old {A,B} -> new):
//     - Up (dir <= 1): 00->10, 10->11, 11->01, 01->00.
//     - Down (dir <= 0): 00->01, 01->11, 11->10, 10->00.
//     - Exactly one channel updated: step <= 1 for one cycle, dir updated.
//     - Both channels updated on the same edge: err <= 1 for one cycle, step stays 0, dir holds,
//       state_q takes the new value (resync, no return to ACQ).
//   Latency:
//     - Input first sampled into a_s1 at edge k -> step/state_q update at edge k+DEB_CYCLES+1.
//     - DEB_CYCLES=4 gives 5 edges.
//   Step rate:
//     - At most one step per DEB_CYCLES edges per channel.
//     - step and err are never high in the same cycle; neither is ever high for 2 consecutive cycles.
// TESTING (DEB_CYCLES=4)
//   1 Hold a=b=1, release rst -> ACQ ends, state_q=11; step=0 and err=0 throughout; dir=1.
//   2 From 00 drive 10,11,01,00, each held 10 cycles -> 4 step pulses, dir=1 at each.
//     Each pulse occurs 5 edges after the change is sampled.
//   3 From 00 drive 01,11,10,00 -> 4 step pulses, dir=0 after the first; state_q ends at 00.
//   4 A high for 3 cycles then low -> no step, state_q stays 00.
//     A high for 4 cycles -> exactly one step, dir=1, state_q=10.
//   5 In TRACK at 00, toggle a and b in the same cycle -> one err pulse, no step,
//     dir unchanged, state_q=11.
//   6 Assert rst for 1 cycle, 2 edges into a debounce -> next edge outputs at reset values.
//     No step follows; FSM re-acquires from current inputs.

Source files
------------

// File: rtl/quad_step_decoder.sv
// quad_step_decoder
//   Front end for the 4-bit up/down counter stage. It takes two asynchronous
//   quadrature channels and produces a single-cycle step pulse, a direction
//   level and an illegal-transition pulse, all synchronous to clk.
//   Internally it uses a 2-FF synchroniser, a per-channel debounce filter and
//   an acquire phase after reset.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous, active-high reset
//   a_in     in   quadrature channel A (asynchronous)
//   b_in     in   quadrature channel B (asynchronous)
//   step     out  one-cycle pulse per legal quadrature transition
//   dir      out  direction of the last legal step (1 = up, A leads B)
//   err      out  one-cycle pulse when both filtered channels change together
//   state_q  out  current filtered {A,B}
module quad_step_decoder #(
    parameter int DEB_CYCLES = 4,
    parameter int DEB_W      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_in,
    input  logic       b_in,
    output logic       step,
    output logic       dir,
    output logic       err,
    output logic [1:0] state_q
);

    typedef enum logic {ACQ, TRACK} state_t;

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    state_t           st, st_nxt;
    logic             a_s1, a_s2, b_s1, b_s2;
    logic [1:0]       prev_s2;
    logic [DEB_W-1:0] acq_cnt, acq_cnt_nxt;
    logic [DEB_W-1:0] a_cnt, a_cnt_nxt, b_cnt, b_cnt_nxt;
    logic             a_f, a_f_nxt, b_f, b_f_nxt;
    logic             a_upd, b_upd;
    logic             step_nxt, err_nxt, dir_nxt;

    // True for the four up transitions; only called with single-channel changes.
    function automatic logic decode_up(input logic [1:0] old_ab, input logic [1:0] new_ab);
        case ({old_ab, new_ab})
            4'b0010, 4'b1011, 4'b1101, 4'b0100: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    always_comb begin
        st_nxt      = st;
        acq_cnt_nxt = acq_cnt;
        a_cnt_nxt   = a_cnt;
        b_cnt_nxt   = b_cnt;
        a_f_nxt     = a_f;
        b_f_nxt     = b_f;
        a_upd       = 1'b0;
        b_upd       = 1'b0;
        step_nxt    = 1'b0;
        err_nxt     = 1'b0;
        dir_nxt     = dir;

        case (st)
            ACQ: begin
                a_cnt_nxt = '0;
                b_cnt_nxt = '0;
                // Need DEB_CYCLES consecutive edges with an unchanged synced pair.
                if ({a_s2, b_s2} != prev_s2) begin
                    acq_cnt_nxt = '0;
                end else if (acq_cnt == DEB_LAST) begin
                    a_f_nxt     = a_s2;
                    b_f_nxt     = b_s2;
                    acq_cnt_nxt = '0;
                    st_nxt      = TRACK;
                end else begin
                    acq_cnt_nxt = acq_cnt + 1'b1;
                end
            end

            TRACK: begin
                if (a_s2 != a_f) begin
                    if (a_cnt == DEB_LAST) begin
                        a_upd     = 1'b1;
                        a_f_nxt   = a_s2;
                        a_cnt_nxt = '0;
                    end else begin
                        a_cnt_nxt = a_cnt + 1'b1;
                    end
                end else begin
                    a_cnt_nxt = '0;
                end

                if (b_s2 != b_f) begin
                    if (b_cnt == DEB_LAST) begin
                        b_upd     = 1'b1;
                        b_f_nxt   = b_s2;
                        b_cnt_nxt = '0;
                    end else begin
                        b_cnt_nxt = b_cnt + 1'b1;
                    end
                end else begin
                    b_cnt_nxt = '0;
                end

                // Both channels moving at once is a lost step: flag it and resync
                // to the new pair without touching dir.
                if (a_upd && b_upd) begin
                    err_nxt = 1'b1;
                end else if (a_upd || b_upd) begin
                    step_nxt = 1'b1;
                    dir_nxt  = decode_up({a_f, b_f}, {a_f_nxt, b_f_nxt});
                end
            end

            default: st_nxt = ACQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= ACQ;
            a_s1    <= 1'b0;
            a_s2    <= 1'b0;
            b_s1    <= 1'b0;
            b_s2    <= 1'b0;
            prev_s2 <= 2'b00;
            acq_cnt <= '0;
            a_cnt   <= '0;
            b_cnt   <= '0;
            a_f     <= 1'b0;
            b_f     <= 1'b0;
            step    <= 1'b0;
            err     <= 1'b0;
            dir     <= 1'b1;
        end else begin
            st      <= st_nxt;
            a_s1    <= a_in;
            a_s2    <= a_s1;
            b_s1    <= b_in;
            b_s2    <= b_s1;
            prev_s2 <= {a_s2, b_s2};
            acq_cnt <= acq_cnt_nxt;
            a_cnt   <= a_cnt_nxt;
            b_cnt   <= b_cnt_nxt;
            a_f     <= a_f_nxt;
            b_f     <= b_f_nxt;
            step    <= step_nxt;
            err     <= err_nxt;
            dir     <= dir_nxt;
        end
    end

    assign state_q = {a_f, b_f};

endmodule

// File: tb/tb_quad_step_decoder.sv
module tb_quad_step_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_in = 1'b0;
    logic       b_in = 1'b0;
    logic       step, dir, err;
    logic [1:0] state_q;

    int checks = 0;
    int errors = 0;

    quad_step_decoder #(.DEB_CYCLES(4), .DEB_W(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_in    (a_in),
        .b_in    (b_in),
        .step    (step),
        .dir     (dir),
        .err     (err),
        .state_q (state_q)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic       a;
        logic       b;
        logic [1:0] exp_state;
        logic       exp_dir;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Apply a new input pair and check the pulse lands exactly 5 edges after
    // the edge that first samples it, then hold for a total of 10 cycles.
    task automatic apply_step(input logic a, input logic b, input logic [1:0] exp_state,
                              input logic exp_dir, input string name);
        a_in = a;
        b_in = b;
        repeat (5) tick();
        check({name, " step_early"}, {31'd0, step}, 32'd0);
        tick();
        check({name, " step"}, {31'd0, step}, 32'd1);
        check({name, " err"}, {31'd0, err}, 32'd0);
        check({name, " dir"}, {31'd0, dir}, {31'd0, exp_dir});
        check({name, " state"}, {30'd0, state_q}, {30'd0, exp_state});
        tick();
        check({name, " step_one_cycle"}, {31'd0, step}, 32'd0);
        repeat (3) tick();
    endtask

    initial begin
        int pulses;
        vecs[0] = '{1'b1, 1'b0, 2'b10, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 2'b11, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 2'b01, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 2'b00, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 2'b01, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 2'b11, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 2'b10, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 2'b00, 1'b0};

        // Test 1: acquire at 11
        a_in = 1'b1;
        b_in = 1'b1;
        rst  = 1'b1;
        repeat (3) tick();
        check("rst state", {30'd0, state_q}, 32'd0);
        check("rst dir", {31'd0, dir}, 32'd1);
        check("rst step", {31'd0, step}, 32'd0);
        check("rst err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (step || err) pulses++;
        end
        check("acq pulses", pulses, 0);
        check("acq state", {30'd0, state_q}, 32'd3);
        check("acq dir", {31'd0, dir}, 32'd1);

        // Re-acquire at 00 for the stepping tests
        a_in = 1'b0;
        b_in = 1'b0;
        rst  = 1'b1;
        tick();
        rst = 1'b0;
        repeat (15) tick();
        check("acq00 state", {30'd0, state_q}, 32'd0);

        // Tests 2 and 3: up then down sequences
        for (int i = 0; i < 8; i++) begin
            apply_step(vecs[i].a, vecs[i].b, vecs[i].exp_state, vecs[i].exp_dir,
                       $sformatf("vec%0d", i));
        end

        // Test 4a: 3-cycle glitch on A is filtered out
        a_in = 1'b1;
        repeat (3) tick();
        a_in = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (step || err) pulses++;
        end
        check("glitch pulses", pulses, 0);
        check("glitch state", {30'd0, state_q}, 32'd0);

        // Test 4b: A held long enough gives exactly one up step
        apply_step(1'b1, 1'b0, 2'b10, 1'b1, "a_hold");
        apply_step(1'b0, 1'b0, 2'b00, 1'b0, "a_back");

        // Test 5: both channels change together
        a_in = 1'b1;
        b_in = 1'b1;
        repeat (5) tick();
        check("both err_early", {31'd0, err}, 32'd0);
        tick();
        check("both err", {31'd0, err}, 32'd1);
        check("both step", {31'd0, step}, 32'd0);
        check("both dir", {31'd0, dir}, 32'd0);
        check("both state", {30'd0, state_q}, 32'd3);
        tick();
        check("both err_one_cycle", {31'd0, err}, 32'd0);
        repeat (5) tick();

        // Test 6: reset in the middle of a debounce
        a_in = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("midrst state", {30'd0, state_q}, 32'd0);
        check("midrst step", {31'd0, step}, 32'd0);
        check("midrst err", {31'd0, err}, 32'd0);
        check("midrst dir", {31'd0, dir}, 32'd1);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (step || err) pulses++;
        end
        check("reacq pulses", pulses, 0);
        check("reacq state", {30'd0, state_q}, 32'd1);
        check("reacq dir", {31'd0, dir}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
